// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_DONE,
    WR_DRAIN
  } bridge_state_t;

  localparam logic [31:0] POISON_WORD = 32'hDEADBEEF;
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/post_write_buf.sv
// Single-entry posted write buffer: holds one store
// (word address, data, lanes) until the bridge drains it.
module post_write_buf #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clr,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   data_i,
  input  logic [3:0]    be_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [31:0]   data_o,
  output logic [3:0]    be_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    be_q, be_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (clr) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      be_d    = be_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign be_o    = be_q;

endmodule

// File: rtl/mips_bus_bridge.sv
// Avalon-style CPU bus to req/ack memory port bridge with a
// posted write buffer, read-after-write ordering and a watchdog.
module mips_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int MEM_AW         = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic              waitrequest,
  output logic [31:0]       readdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  bridge_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;

  logic              wb_load, wb_clr, wb_valid;
  logic [MEM_AW-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [3:0]        wb_be;
  logic              wait_c;
  logic [MEM_AW-1:0] cpu_waddr;
  logic              unused_addr;

  assign cpu_waddr   = address[MEM_AW+1:2];
  assign unused_addr = ^{address[31:MEM_AW+2], address[1:0]};

  post_write_buf #(.AW(MEM_AW)) u_wbuf (
    .clk     (clk),
    .rst_n   (reset),
    .load    (wb_load),
    .clr     (wb_clr),
    .addr_i  (cpu_waddr),
    .data_i  (writedata),
    .be_i    (byteenable),
    .valid_o (wb_valid),
    .addr_o  (wb_addr),
    .data_o  (wb_data),
    .be_o    (wb_be)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    wb_load = 1'b0;
    wb_clr  = 1'b0;
    wait_c  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (wb_valid) begin
          // a leftover buffered store always drains before any read
          wait_c  = read | write;
          state_d = WR_DRAIN;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = wb_addr;
          wdata_d = wb_data;
          be_d    = wb_be;
          cnt_d   = '0;
        end else if (read) begin
          state_d = RD_REQ;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = cpu_waddr;
          be_d    = byteenable;
          cnt_d   = '0;
        end else if (write) begin
          wait_c = 1'b0;
          if (byteenable != 4'b0000) begin
            wb_load = 1'b1;
            state_d = WR_DRAIN;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = cpu_waddr;
            wdata_d = writedata;
            be_d    = byteenable;
            cnt_d   = '0;
          end
        end else begin
          wait_c = 1'b0;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = RD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = POISON_WORD;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_DONE: begin
        wait_c  = 1'b0;
        state_d = IDLE;
      end
      WR_DRAIN: begin
        wait_c = read | write;
        if (mem_ack || cnt_q == CNT_LAST) begin
          wb_clr  = 1'b1;
          req_d   = 1'b0;
          err_d   = err_q | ~mem_ack;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  assign waitrequest = ~reset | wait_c;
  assign readdata    = rdata_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign bus_error   = err_q;

endmodule
